// File: rtl/sdspi_byte_engine.sv
// SD-card SPI byte shifter: mode-0 SCK/MOSI/CS_n generation, MISO byte capture.
// Optional macro SDSPI_MISO_SYNC_EN: two-flop MISO synchronizer, completion delayed 2 cycles.
module sdspi_byte_engine #(
  parameter int SPDBITS = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [SPDBITS-1:0] i_cfg_spd,
  input  logic               i_cs,
  input  logic               i_stb,
  input  logic [7:0]         i_byte,
  output logic               o_busy,
  output logic               o_stb,
  output logic [7:0]         o_byte,
  output logic               o_cs_n,
  output logic               o_sck,
  output logic               o_mosi,
  input  logic               i_miso
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [SPDBITS-1:0] spd_q, spd_d, cnt_q, cnt_d;
  logic [6:0]         tx_q, tx_d;
  logic [7:0]         rx_q, rx_d, byte_q, byte_d;
  logic [4:0]         tog_q, tog_d;
  logic               sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, stb_q, stb_d;
  logic               samp_now, samp_en, samp_bit;

  // Next edge is a rising SCK toggle (toggle count even before the toggle).
  assign samp_now = (state_q == ST_SHIFT) && (cnt_q == '0) && !tog_q[0];

`ifdef SDSPI_MISO_SYNC_EN
  logic [1:0] miso_q, samp_q;
  logic       drn_q, drn_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      miso_q <= '0;
      samp_q <= '0;
      drn_q  <= 1'b0;
    end else begin
      miso_q <= {miso_q[0], i_miso};
      samp_q <= {samp_q[0], samp_now};
      drn_q  <= drn_d;
    end
  end

  assign samp_en  = samp_q[1];
  assign samp_bit = miso_q[1];
`else
  assign samp_en  = samp_now;
  assign samp_bit = i_miso;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      spd_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      byte_q  <= '0;
      tog_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      byte_q  <= byte_d;
      tog_q   <= tog_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    byte_d  = byte_q;
    tog_d   = tog_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    stb_d   = 1'b0;
`ifdef SDSPI_MISO_SYNC_EN
    drn_d   = drn_q;
`endif
    if (samp_en) rx_d = {rx_q[6:0], samp_bit};
    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          state_d = ST_SHIFT;
          spd_d   = i_cfg_spd;
          cnt_d   = i_cfg_spd;
          tx_d    = i_byte[6:0];
          mosi_d  = i_byte[7];
          tog_d   = '0;
          rx_d    = '0;
        end else begin
          // CS only follows the request between bytes, so mid-byte changes wait.
          cs_n_d = !i_cs;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = spd_q;
          sck_d = !sck_q;
          tog_d = tog_q + 5'd1;
          if (tog_q == 5'd15) begin
            mosi_d  = 1'b1;
`ifdef SDSPI_MISO_SYNC_EN
            state_d = ST_DRAIN;
            drn_d   = 1'b0;
`else
            state_d = ST_IDLE;
            stb_d   = 1'b1;
            byte_d  = rx_q;
`endif
          end else if (tog_q[0]) begin
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - SPDBITS'(1);
        end
      end
`ifdef SDSPI_MISO_SYNC_EN
      ST_DRAIN: begin
        // Wait out the synchronizer so the last MISO bit lands before the strobe.
        if (drn_q) begin
          state_d = ST_IDLE;
          stb_d   = 1'b1;
          byte_d  = rx_q;
        end else begin
          drn_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_stb  = stb_q;
  assign o_byte = byte_q;
  assign o_cs_n = cs_n_q;
  assign o_sck  = sck_q;
  assign o_mosi = mosi_q;

endmodule

// File: tb/tb_sdspi_byte_engine.sv
// Directed bench for sdspi_byte_engine with a mode-0 card model driving MISO.
module tb_sdspi_byte_engine;

`ifdef SDSPI_MISO_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  logic       i_clk, i_reset, i_cs, i_stb, i_miso;
  logic [6:0] i_cfg_spd;
  logic [7:0] i_byte;
  logic       o_busy, o_stb, o_cs_n, o_sck, o_mosi;
  logic [7:0] o_byte;

  sdspi_byte_engine #(.SPDBITS(7)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cfg_spd(i_cfg_spd), .i_cs(i_cs),
    .i_stb(i_stb), .i_byte(i_byte), .o_busy(o_busy), .o_stb(o_stb),
    .o_byte(o_byte), .o_cs_n(o_cs_n), .o_sck(o_sck), .o_mosi(o_mosi),
    .i_miso(i_miso)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Card model: presents card_b MSB first, advancing one bit per falling SCK.
  int          fall_cnt = 0;
  int          fall0;
  logic [7:0]  card_b;
  always @(negedge o_sck) fall_cnt++;
  assign i_miso = card_b[3'(7 - (fall_cnt - fall0))];

  int          rise_cnt = 0;
  logic [15:0] mosi_log = '0;
  always @(posedge o_sck) begin
    rise_cnt++;
    mosi_log = {mosi_log[14:0], o_mosi};
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int lat, hi, bad, r0, stb_n;
  logic [7:0] rx;
  logic       busy_at, cs_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the o_stb cycle.
  task automatic xfer(input logic [7:0] b, input logic [6:0] spd, input logic [7:0] card,
                      output int l, output logic [7:0] r, output int h);
    i_cfg_spd = spd; i_byte = b; card_b = card; fall0 = fall_cnt; r0 = rise_cnt; i_stb = 1'b1;
    @(negedge i_clk);
    i_stb = 1'b0;
    l = -1; h = 0; r = 8'h00;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge i_clk);
      if (o_sck) h++;
      if (o_stb) begin
        l = c; r = o_byte;
        break;
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_cs = 1'b0; i_stb = 1'b0; i_byte = 8'h00; i_cfg_spd = '0;
    card_b = 8'hFF; fall0 = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_cs_n", 32'(o_cs_n), 32'h1);
    chk("rst_sck",  32'(o_sck),  32'h0);
    chk("rst_mosi", 32'(o_mosi), 32'h1);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_stb",  32'(o_stb),  32'h0);
    chk("rst_byte", 32'(o_byte), 32'h0);
    i_reset = 1'b0; i_cs = 1'b1;
    @(negedge i_clk);
    chk("cs_assert", 32'(o_cs_n), 32'h0);

    // Single byte at full speed, detailed SCK pattern.
    i_cfg_spd = 7'd0; i_byte = 8'hA5; card_b = 8'h3C; fall0 = fall_cnt; r0 = rise_cnt; i_stb = 1'b1;
    @(negedge i_clk);
    i_stb = 1'b0;
    chk("fs_busy", 32'(o_busy), 32'h1);
    chk("fs_mosi0", 32'(o_mosi), 32'h1);
    chk("fs_sck0", 32'(o_sck), 32'h0);
    bad = 0; lat = -1; stb_n = 0; busy_at = 1'b1; rx = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (c <= 16 && o_sck !== c[0]) bad++;
      if (o_stb) begin
        stb_n++;
        if (lat < 0) begin lat = c; rx = o_byte; busy_at = o_busy; end
      end
    end
    chk("fs_sck_pattern", 32'(bad), 32'h0);
    chk("fs_latency", 32'(lat), 32'(16 + XL));
    chk("fs_rx", 32'(rx), 32'h3C);
    chk("fs_stb_width", 32'(stb_n), 32'h1);
    chk("fs_busy_at_stb", 32'(busy_at), 32'h0);
    chk("fs_rises", 32'(rise_cnt - r0), 32'h8);
    chk("fs_mosi_bits", 32'(mosi_log[7:0]), 32'hA5);
    chk("fs_mosi_idle", 32'(o_mosi), 32'h1);

    // Divided clock: half-period of 4 clocks.
    xfer(8'hFF, 7'd3, 8'h00, lat, rx, hi);
    chk("div_latency", 32'(lat), 32'(64 + XL));
    chk("div_rx", 32'(rx), 32'h00);
    chk("div_sck_high_cycles", 32'(hi), 32'd32);
    chk("div_rises", 32'(rise_cnt - r0), 32'h8);
    chk("div_mosi_bits", 32'(mosi_log[7:0]), 32'hFF);

    // Back-to-back: i_stb held, second byte presented on the o_stb cycle.
    @(negedge i_clk);
    i_cfg_spd = 7'd0; i_byte = 8'h40; card_b = 8'h81; fall0 = fall_cnt; r0 = rise_cnt; i_stb = 1'b1;
    @(negedge i_clk);
    lat = -1; rx = 8'h00;
    for (int c = 1; c <= 200; c++) begin
      @(negedge i_clk);
      if (o_stb) begin lat = c; rx = o_byte; break; end
    end
    chk("b2b_latency1", 32'(lat), 32'(16 + XL));
    chk("b2b_rx1", 32'(rx), 32'h81);
    i_byte = 8'h00; card_b = 8'h7E; fall0 = fall_cnt;
    @(negedge i_clk);
    i_stb = 1'b0;
    chk("b2b_accept2", 32'(o_busy), 32'h1);
    lat = -1; rx = 8'h00;
    for (int c = 1; c <= 200; c++) begin
      @(negedge i_clk);
      if (o_stb) begin lat = c; rx = o_byte; break; end
    end
    chk("b2b_latency2", 32'(lat), 32'(16 + XL));
    chk("b2b_rx2", 32'(rx), 32'h7E);
    chk("b2b_rises", 32'(rise_cnt - r0), 32'd16);
    chk("b2b_mosi_bits", 32'(mosi_log), 32'h4000);

    // CS deferral: drop i_cs after toggle 5.
    @(negedge i_clk);
    i_cfg_spd = 7'd0; i_byte = 8'h55; card_b = 8'h00; fall0 = fall_cnt; i_stb = 1'b1;
    @(negedge i_clk);
    i_stb = 1'b0;
    bad = 0; busy_at = 1'b1; cs_at = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge i_clk);
      if (c == 5) i_cs = 1'b0;
      if (c >= 6 && c <= 16 + XL && o_cs_n !== 1'b0) bad++;
      if (c == 16 + XL) busy_at = o_busy;
      if (c == 17 + XL) cs_at = o_cs_n;
    end
    chk("csd_held_low", 32'(bad), 32'h0);
    chk("csd_busy_fall", 32'(busy_at), 32'h0);
    chk("csd_cs_release", 32'(cs_at), 32'h1);
    xfer(8'hFF, 7'd0, 8'hA5, lat, rx, hi);
    chk("csd_nocs_latency", 32'(lat), 32'(16 + XL));
    chk("csd_nocs_rx", 32'(rx), 32'hA5);
    chk("csd_nocs_mosi", 32'(mosi_log[7:0]), 32'hFF);
    chk("csd_nocs_cs_n", 32'(o_cs_n), 32'h1);

    // Reset mid-byte.
    i_cs = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_cfg_spd = 7'd0; i_byte = 8'h12; card_b = 8'h99; fall0 = fall_cnt; i_stb = 1'b1;
    @(negedge i_clk);
    i_stb = 1'b0;
    repeat (7) @(negedge i_clk);
    chk("mid_sck_high", 32'(o_sck), 32'h1);
    i_reset = 1'b1;
    #1;
    chk("mid_rst_sck",  32'(o_sck),  32'h0);
    chk("mid_rst_mosi", 32'(o_mosi), 32'h1);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_cs_n", 32'(o_cs_n), 32'h1);
    chk("mid_rst_byte", 32'(o_byte), 32'h0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    stb_n = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_stb) stb_n++;
    end
    chk("mid_no_stb", 32'(stb_n), 32'h0);
    xfer(8'hC3, 7'd1, 8'h5A, lat, rx, hi);
    chk("post_latency", 32'(lat), 32'(32 + XL));
    chk("post_rx", 32'(rx), 32'h5A);
    chk("post_mosi", 32'(mosi_log[7:0]), 32'hC3);
    chk("post_rises", 32'(rise_cnt - r0), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
